bin2csd_arb: RTL and testbench

BIN2CSD_ARB -- requirements
Module: bin2csd_arb

---
 rtl/bin2csd_pkg.sv | 17 +
 rtl/bin2csd.sv | 38 +++
 rtl/bin2csd_arb.sv | 105 ++++++++++
 tb/tb_bin2csd_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2csd_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// bin2csd_pkg: CSD digit codes and requester count shared by the arbiter
// Rev 1.0
// ------------------------------------------------------------------
package bin2csd_pkg;

  typedef logic [1:0] csd_digit_t;

  localparam csd_digit_t CSD_0  = 2'b00;
  localparam csd_digit_t CSD_P1 = 2'b01;
  localparam csd_digit_t CSD_M1 = 2'b10;

  localparam int NREQ = 2;

endpackage : bin2csd_pkg
`default_nettype wire

// File: rtl/bin2csd.sv
`default_nettype none
// ------------------------------------------------------------------
// bin2csd: combinational two's-complement to canonical signed digit
// Rev 1.0
// ------------------------------------------------------------------
module bin2csd
  import bin2csd_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0]   i_x,
  output logic [2*W-1:0] o_y
);

  // i_x shifted down one place with sign extension: bit k is the neighbour above bit k
  logic [W-1:0] w_x_up;
  assign w_x_up = {i_x[W-1], i_x[W-1:1]};

  always_comb begin
    logic w_c;
    logic w_cn;
    w_c  = 1'b0;
    w_cn = 1'b0;
    o_y  = '0;
    // Reitwiesner recoding: a digit is non-zero where bit and carry differ
    for (int k = 0; k < W; k++) begin
      w_cn = (i_x[k] & w_x_up[k]) | (i_x[k] & w_c) | (w_x_up[k] & w_c);
      if (i_x[k] ^ w_c) begin
        o_y[2*k +: 2] = w_cn ? CSD_M1 : CSD_P1;
      end else begin
        o_y[2*k +: 2] = CSD_0;
      end
      w_c = w_cn;
    end
  end

endmodule : bin2csd
`default_nettype wire

// File: rtl/bin2csd_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// bin2csd_arb: round-robin sharing of one bin2csd between two requesters
// Rev 1.0
// ------------------------------------------------------------------
module bin2csd_arb
  import bin2csd_pkg::*;
#(
  parameter int W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*W-1:0]      req_x,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [2*NREQ*W-1:0]    rsp_y,
  output logic                   busy,
  output logic [15:0]            conv_cnt
);

  logic                r_s1_valid;
  logic                r_s1_id;
  logic [W-1:0]        r_s1_x;
  logic [NREQ-1:0]     r_rsp_valid;
  logic [2*NREQ*W-1:0] r_rsp_y;
  logic                r_rr_ptr;
  logic [15:0]         r_conv_cnt;

  logic [NREQ-1:0]     w_elig;
  logic [NREQ-1:0]     w_grant;
  logic                w_grant_id;
  logic [W-1:0]        w_grant_x;
  logic [2*W-1:0]      w_csd;

  // A requester already in S1 is skipped, which caps each one at one issue per two cycles
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req_valid[i]
                & (~r_s1_valid | (r_s1_id != 1'(i)))
                & (~r_rsp_valid[i] | rsp_ready[i]);
    end
  end

  always_comb begin
    w_grant = w_elig;
    if (w_elig == 2'b11) begin
      w_grant = r_rr_ptr ? 2'b10 : 2'b01;
    end
    if (rst) begin
      w_grant = '0;
    end
  end

  assign w_grant_id = w_grant[1];
  assign w_grant_x  = w_grant[1] ? req_x[W +: W] : req_x[0 +: W];

  bin2csd #(
    .W (W)
  ) u_bin2csd (
    .i_x (r_s1_x),
    .o_y (w_csd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_id     <= 1'b0;
      r_s1_x      <= '0;
      r_rsp_valid <= '0;
      r_rsp_y     <= '0;
      r_rr_ptr    <= 1'b0;
      r_conv_cnt  <= '0;
    end else begin
      r_s1_valid <= |w_grant;
      if (|w_grant) begin
        r_s1_id  <= w_grant_id;
        r_s1_x   <= w_grant_x;
        r_rr_ptr <= ~w_grant_id;
      end
      // S2 write takes priority over the consumer's clear
      for (int i = 0; i < NREQ; i++) begin
        if (r_s1_valid && (r_s1_id == 1'(i))) begin
          r_rsp_valid[i]              <= 1'b1;
          r_rsp_y[i*2*W +: 2*W]       <= w_csd;
        end else if (r_rsp_valid[i] && rsp_ready[i]) begin
          r_rsp_valid[i]              <= 1'b0;
        end
      end
      if (r_s1_valid && (r_conv_cnt != 16'hFFFF)) begin
        r_conv_cnt <= r_conv_cnt + 16'd1;
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;
  assign conv_cnt  = r_conv_cnt;
  assign busy      = ~rst & (r_s1_valid | (|r_rsp_valid));

endmodule : bin2csd_arb
`default_nettype wire

// File: tb/tb_bin2csd_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_bin2csd_arb: directed and soak checks of bin2csd_arb against a transaction model
// Rev 1.0
// ------------------------------------------------------------------
module tb_bin2csd_arb;

  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_x;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [4*W-1:0] rsp_y;
  logic           busy;
  logic [15:0]    conv_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bin2csd_arb #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .busy      (busy),
    .conv_cnt  (conv_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Non-adjacent form of the signed value, built digit by digit with integer arithmetic
  function automatic logic [2*W-1:0] naf(input logic [W-1:0] x);
    int v;
    logic [2*W-1:0] y;
    v = int'($signed(x));
    y = '0;
    for (int k = 0; k < W; k++) begin
      if ((v & 1) != 0) begin
        if ((v & 3) == 1) begin
          y[2*k +: 2] = 2'b01;
          v = v - 1;
        end else begin
          y[2*k +: 2] = 2'b10;
          v = v + 1;
        end
      end
      v = v >>> 1;
    end
    return y;
  endfunction

  // Transaction-level model: one pending conversion plus one result slot per requester
  bit             m_known = 1'b0;
  bit             m_pv;
  int             m_pid;
  logic [W-1:0]   m_px;
  bit             m_bv [2];
  logic [2*W-1:0] m_by [2];
  int             m_rr;
  int             m_cnt;
  logic [1:0]     mon_acc = 2'b00;
  logic [W-1:0]   exp_q [2][$];

  always @(negedge clk) begin : monitor
    logic [1:0] elig;
    logic [1:0] gnt;
    int bad;
    for (int i = 0; i < 2; i++)
      elig[i] = req_valid[i] && !(m_pv && m_pid == i) && (!m_bv[i] || rsp_ready[i]);
    gnt = (elig == 2'b11) ? ((m_rr == 0) ? 2'b01 : 2'b10) : elig;
    if (rst) gnt = 2'b00;

    if (m_known) begin
      check("req_ready", req_ready, gnt);
      check("rsp_valid", rsp_valid, {m_bv[1], m_bv[0]});
      check("rsp_y", rsp_y, {m_by[1], m_by[0]});
      check("busy", busy, !rst && (m_pv || m_bv[0] || m_bv[1]));
      check("conv_cnt", conv_cnt, m_cnt);
    end
    check("ready_onehot", ($countones(req_ready) <= 1), 1);
    bad = 0;
    for (int i = 0; i < 2; i++)
      for (int d = 0; d < W; d++)
        if (rsp_valid[i] && rsp_y[i*2*W + 2*d +: 2] == 2'b11) bad++;
    check("no_code11", bad, 0);

    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            check("sb_unexpected", 1, 0);
          end else begin
            logic [W-1:0] xf;
            xf = exp_q[i].pop_front();
            check("sb_result", rsp_y[i*2*W +: 2*W], naf(xf));
          end
        end
        if (req_valid[i] && req_ready[i]) exp_q[i].push_back(req_x[i*W +: W]);
      end
    end
    mon_acc = req_valid & req_ready;

    if (rst) begin
      m_known = 1'b1;
      m_pv = 0; m_pid = 0; m_px = '0; m_rr = 0; m_cnt = 0;
      for (int i = 0; i < 2; i++) begin
        m_bv[i] = 0; m_by[i] = '0; exp_q[i].delete();
      end
    end else if (m_known) begin
      for (int i = 0; i < 2; i++) begin
        if (m_pv && m_pid == i) begin
          m_bv[i] = 1;
          m_by[i] = naf(m_px);
          if (m_cnt < 65535) m_cnt++;
        end else if (m_bv[i] && rsp_ready[i]) begin
          m_bv[i] = 0;
        end
      end
      if (gnt != 2'b00) begin
        m_pv  = 1;
        m_pid = gnt[1] ? 1 : 0;
        m_px  = req_x[m_pid*W +: W];
        m_rr  = 1 - m_pid;
      end else begin
        m_pv = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [2*W-1:0] y0;
    int cnt0, cnt1, issued, accepted, cyc;
    rst = 1'b1; req_valid = 2'b00; req_x = '0; rsp_ready = 2'b11;
    repeat (3) tick();

    // Reset state, with requests present: nothing may be granted
    req_valid = 2'b11;
    #1;
    check("rst_ready", req_ready, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_cnt", conv_cnt, 0);
    check("rst_rsp_y", rsp_y, 0);
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    tick();

    // Single request, x = 7
    req_x[4:0] = 5'b00111; req_valid = 2'b01;
    #1; check("t1_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    check("t1_no_early", rsp_valid, 2'b00);
    tick();
    check("t1_valid", rsp_valid, 2'b01);
    check("t1_y", rsp_y[9:0], 10'b0001000010);
    check("t1_cnt", conv_cnt, 1);
    tick();
    check("t1_cleared", rsp_valid, 2'b00);

    // Contention after reset
    rst = 1'b1; tick(); rst = 1'b0;
    req_x = {5'b11111, 5'b11111}; req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      #1;
      check("t2_grant", req_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
      if (n == 2) begin
        check("t2_valid0", rsp_valid[0], 1);
        check("t2_y", rsp_y[9:0], 10'b0000000010);
      end
      tick();
    end
    req_valid = 2'b00;
    repeat (3) tick();

    // Backpressure on requester 0
    rsp_ready = 2'b10; req_x = {5'b01010, 5'b00101}; req_valid = 2'b11;
    cnt0 = 0; cnt1 = 0; y0 = '0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c == 0) check("t3_first", req_ready, 2'b01);
      else begin
        cnt0 += int'(req_ready[0]);
        cnt1 += int'(req_ready[1]);
      end
      if (c == 2) begin
        y0 = rsp_y[9:0];
        check("t3_y0", y0, 10'b0000010001);
      end
      if (c > 2) begin
        check("t3_hold_valid", rsp_valid[0], 1);
        check("t3_stable", rsp_y[9:0], y0);
      end
      tick();
    end
    check("t3_no_regrant0", cnt0, 0);
    check("t3_req1_served", cnt1, 4);
    rsp_ready = 2'b11; req_valid = 2'b00;
    repeat (4) tick();

    // Reset the cycle after an accept
    req_x[4:0] = 5'b10000; req_valid = 2'b01;
    #1; check("t4_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00; rst = 1'b1;
    tick(); rst = 1'b0;
    #1;
    check("t4_valid", rsp_valid, 2'b00);
    check("t4_cnt", conv_cnt, 0);
    tick();
    check("t4_still0", rsp_valid, 2'b00);
    req_valid = 2'b11;
    #1; check("t4_rr0", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    repeat (3) tick();

    // Random soak
    issued = 0; accepted = 0; cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && mon_acc[i]) begin
          accepted++;
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && issued < 10000 && $urandom_range(3) != 0) begin
          req_x[i*W +: W] = W'($urandom);
          req_valid[i] = 1'b1;
          issued++;
        end
        rsp_ready[i] = ($urandom_range(3) != 0);
      end
      tick();
      cyc++;
    end
    check("soak_done", accepted, 10000);
    req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (4) tick();
    check("drain_q0", exp_q[0].size(), 0);
    check("drain_q1", exp_q[1].size(), 0);
    check("drain_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_bin2csd_arb
`default_nettype wire
